// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BURST} arb_state_t;

  localparam logic [3:0] HDR_TAG    = 4'hA;
  localparam int         DEF_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the lowest requesting index at or above
// the pointer wins, with wrap-around at NUM_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
)(
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_gnt;

  // Scanning the rotated view from the top down leaves the nearest requester
  // to the pointer as the final assignment; the index is un-rotated mod NUM_REQ.
  always_comb begin
    w_idx = '0;
    w_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, i_ptr} + (IDW + 1)'(i);
      if (w_idx >= (IDW + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW + 1)'(NUM_REQ);
      end
      if (i_req[w_idx[IDW-1:0]]) begin
        w_gnt = w_idx[IDW-1:0];
      end
    end
  end

  assign o_gnt_idx = w_gnt;
  assign o_any     = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART transmitter between NUM_REQ
// byte-stream clients, with an optional client tag byte ahead of each burst.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16,
  parameter bit HDR_EN    = 1'b1
)(
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    i_req_data,
  input  logic [NUM_REQ-1:0]                i_req_last,
  output logic [NUM_REQ-1:0]                o_req_ready,
  output logic                              o_tx_valid,
  output logic [DATA_W-1:0]                 o_tx_data,
  input  logic                              i_tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]        o_grant_id,
  output logic                              o_busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  arb_state_t     r_state;
  arb_state_t     w_next_state;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_beat_cnt;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_ptr_next;
  logic           w_any;
  logic           w_accept;
  logic           w_term;
  logic [7:0]     w_tag;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_pick),
    .o_any     (w_any)
  );

  assign w_tag      = {HDR_TAG, 4'(r_grant)};
  assign w_ptr_next = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign o_grant_id = r_grant;
  assign o_busy     = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The burst path is purely combinational so a streaming client reaches one byte per cycle.
  always_comb begin
    w_next_state = r_state;
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_req_ready  = '0;
    w_accept     = 1'b0;
    w_term       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next_state = HDR_EN ? ST_HDR : ST_BURST;
        end
      end
      ST_HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = DATA_W'(w_tag);
        if (i_tx_ready) begin
          w_next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        o_tx_valid           = i_req_valid[r_grant];
        o_tx_data            = i_req_data[r_grant];
        o_req_ready[r_grant] = i_tx_ready;
        w_accept             = i_req_valid[r_grant] & i_tx_ready;
        w_term               = w_accept & (i_req_last[r_grant] |
                                           (r_beat_cnt == CW'(MAX_BURST - 1)));
        if (w_term) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A forced release looks the same as a client-ended burst: the pointer moves past the owner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_grant <= w_pick;
      end
      if (w_term) begin
        r_beat_cnt <= '0;
        r_rr_ptr   <= w_ptr_next;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a tagged instance with MAX_BURST=4 and
// an untagged instance with MAX_BURST=16 share one set of client inputs.
module tb_uart_tx_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       reqValid;
  logic [3:0][7:0]  reqData;
  logic [3:0]       reqLast;
  logic             txReady;

  logic [3:0] aReqReady, bReqReady;
  logic       aTxValid, bTxValid;
  logic [7:0] aTxData, bTxData;
  logic [1:0] aGrant, bGrant;
  logic       aBusy, bBusy;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        txr;
    logic        expTxv;
    logic [7:0]  expData;
    logic [3:0]  expRdy;
    logic        expBusy;
    logic [1:0]  expGrant;
  } vec_t;

  vec_t vecs [21];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .HDR_EN(1'b1)
  ) dutA (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .i_req_data(reqData), .i_req_last(reqLast),
    .o_req_ready(aReqReady), .o_tx_valid(aTxValid), .o_tx_data(aTxData),
    .i_tx_ready(txReady), .o_grant_id(aGrant), .o_busy(aBusy)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .MAX_BURST(16), .HDR_EN(1'b0)
  ) dutB (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .i_req_data(reqData), .i_req_last(reqLast),
    .o_req_ready(bReqReady), .o_tx_valid(bTxValid), .o_tx_data(bTxData),
    .i_tx_ready(txReady), .o_grant_id(bGrant), .o_busy(bBusy)
  );

  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic r,
                              logic ev, logic [7:0] ed, logic [3:0] er, logic eb,
                              logic [1:0] eg);
    vec_t x;
    x.valid = v; x.data = d; x.last = l; x.txr = r;
    x.expTxv = ev; x.expData = ed; x.expRdy = er; x.expBusy = eb; x.expGrant = eg;
    return x;
  endfunction

  task automatic compareVal(string name, logic [31:0] act, logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic r);
    @(negedge clk);
    reqValid = v;
    reqData  = d;
    reqLast  = l;
    txReady  = r;
    #1;
  endtask

  task automatic checkOutput(string name, bit useB, logic expTxv, logic [7:0] expData,
                             logic [3:0] expRdy, logic expBusy, logic [1:0] expGrant);
    logic       txv, busy;
    logic [7:0] data;
    logic [3:0] rdy;
    logic [1:0] grant;
    if (useB) begin
      txv = bTxValid; data = bTxData; rdy = bReqReady; busy = bBusy; grant = bGrant;
    end else begin
      txv = aTxValid; data = aTxData; rdy = aReqReady; busy = aBusy; grant = aGrant;
    end
    compareVal({name, ".txValid"}, 32'(txv), 32'(expTxv));
    compareVal({name, ".txData"}, 32'(data), 32'(expData));
    compareVal({name, ".reqReady"}, 32'(rdy), 32'(expRdy));
    compareVal({name, ".busy"}, 32'(busy), 32'(expBusy));
    if (expBusy) begin
      compareVal({name, ".grantId"}, 32'(grant), 32'(expGrant));
    end
  endtask

  task automatic runStep(string name, bit useB, logic [3:0] v, logic [31:0] d,
                         logic [3:0] l, logic r, logic ev, logic [7:0] ed,
                         logic [3:0] er, logic eb, logic [1:0] eg);
    applyStimulus(v, d, l, r);
    checkOutput(name, useB, ev, ed, er, eb, eg);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    reqValid = '0;
    reqLast  = '0;
    reqData  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] v;

    // Single client with tag, then pointer-at-3 check, then tx_ready toggling 1,0,0,1.
    vecs[0]  = mk(4'b0100, 32'h00110000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[1]  = mk(4'b0100, 32'h00110000, 4'b0000, 1, 1, 8'hA2, 4'b0000, 1, 2);
    vecs[2]  = mk(4'b0100, 32'h00110000, 4'b0000, 1, 1, 8'h11, 4'b0100, 1, 2);
    vecs[3]  = mk(4'b0100, 32'h00220000, 4'b0000, 1, 1, 8'h22, 4'b0100, 1, 2);
    vecs[4]  = mk(4'b0100, 32'h00330000, 4'b0100, 1, 1, 8'h33, 4'b0100, 1, 2);
    vecs[5]  = mk(4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[6]  = mk(4'b1001, 32'h53000050, 4'b1001, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[7]  = mk(4'b1001, 32'h53000050, 4'b1001, 1, 1, 8'hA3, 4'b0000, 1, 3);
    vecs[8]  = mk(4'b1001, 32'h53000050, 4'b1001, 1, 1, 8'h53, 4'b1000, 1, 3);
    vecs[9]  = mk(4'b0001, 32'h00000050, 4'b0001, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[10] = mk(4'b0001, 32'h00000050, 4'b0001, 1, 1, 8'hA0, 4'b0000, 1, 0);
    vecs[11] = mk(4'b0001, 32'h00000050, 4'b0001, 1, 1, 8'h50, 4'b0001, 1, 0);
    vecs[12] = mk(4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[13] = mk(4'b0010, 32'h00006100, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    vecs[14] = mk(4'b0010, 32'h00006100, 4'b0000, 0, 1, 8'hA1, 4'b0000, 1, 1);
    vecs[15] = mk(4'b0010, 32'h00006100, 4'b0000, 1, 1, 8'hA1, 4'b0000, 1, 1);
    vecs[16] = mk(4'b0010, 32'h00006100, 4'b0000, 1, 1, 8'h61, 4'b0010, 1, 1);
    vecs[17] = mk(4'b0010, 32'h00006200, 4'b0010, 0, 1, 8'h62, 4'b0000, 1, 1);
    vecs[18] = mk(4'b0010, 32'h00006200, 4'b0010, 0, 1, 8'h62, 4'b0000, 1, 1);
    vecs[19] = mk(4'b0010, 32'h00006200, 4'b0010, 1, 1, 8'h62, 4'b0010, 1, 1);
    vecs[20] = mk(4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);

    rst      = 1'b1;
    reqValid = 4'hF;
    reqLast  = 4'hF;
    reqData  = 32'hFFFFFFFF;
    txReady  = 1'b1;
    #2;
    checkOutput("resetA", 0, 0, 8'h00, 4'b0000, 0, 0);
    checkOutput("resetB", 1, 0, 8'h00, 4'b0000, 0, 0);
    @(negedge clk);
    reqValid = '0;
    reqLast  = '0;
    rst      = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].txr);
      checkOutput($sformatf("vec%0d", i), 0, vecs[i].expTxv, vecs[i].expData,
                  vecs[i].expRdy, vecs[i].expBusy, vecs[i].expGrant);
    end

    $display("[TB] all four clients, one-byte bursts from reset");
    doReset();
    v = 4'hF;
    for (int k = 0; k < 4; k++) begin
      runStep($sformatf("rr%0d.idle", k), 0, v, 32'h13121110, 4'hF, 1,
              0, 8'h00, 4'b0000, 0, 0);
      runStep($sformatf("rr%0d.tag", k), 0, v, 32'h13121110, 4'hF, 1,
              1, 8'(8'hA0 + k), 4'b0000, 1, 2'(k));
      runStep($sformatf("rr%0d.byte", k), 0, v, 32'h13121110, 4'hF, 1,
              1, 8'(8'h10 + k), 4'(1 << k), 1, 2'(k));
      v[k] = 1'b0;
    end

    $display("[TB] forced release at MAX_BURST with a waiting client");
    runStep("mb.idle0", 0, 4'b0011, 32'h0000D1C0, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("mb.tag0",  0, 4'b0011, 32'h0000D1C0, 4'b0010, 1, 1, 8'hA0, 4'b0000, 1, 0);
    runStep("mb.c0",    0, 4'b0011, 32'h0000D1C0, 4'b0010, 1, 1, 8'hC0, 4'b0001, 1, 0);
    runStep("mb.c1",    0, 4'b0011, 32'h0000D1C1, 4'b0010, 1, 1, 8'hC1, 4'b0001, 1, 0);
    runStep("mb.stall", 0, 4'b0010, 32'h0000D1C2, 4'b0010, 1, 0, 8'hC2, 4'b0001, 1, 0);
    runStep("mb.c2",    0, 4'b0011, 32'h0000D1C2, 4'b0010, 1, 1, 8'hC2, 4'b0001, 1, 0);
    runStep("mb.c3",    0, 4'b0011, 32'h0000D1C3, 4'b0010, 1, 1, 8'hC3, 4'b0001, 1, 0);
    runStep("mb.idle1", 0, 4'b0011, 32'h0000D1C4, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("mb.tag1",  0, 4'b0011, 32'h0000D1C4, 4'b0010, 1, 1, 8'hA1, 4'b0000, 1, 1);
    runStep("mb.d1",    0, 4'b0011, 32'h0000D1C4, 4'b0010, 1, 1, 8'hD1, 4'b0010, 1, 1);
    runStep("mb.idle2", 0, 4'b0001, 32'h000000C4, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("mb.tag2",  0, 4'b0001, 32'h000000C4, 4'b0000, 1, 1, 8'hA0, 4'b0000, 1, 0);
    runStep("mb.c4",    0, 4'b0001, 32'h000000C4, 4'b0000, 1, 1, 8'hC4, 4'b0001, 1, 0);
    runStep("mb.c5",    0, 4'b0001, 32'h000000C5, 4'b0001, 1, 1, 8'hC5, 4'b0001, 1, 0);
    runStep("mb.idle3", 0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);

    $display("[TB] asynchronous reset mid-burst");
    runStep("rs.idle",  0, 4'b1000, 32'hF0000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("rs.tag",   0, 4'b1000, 32'hF0000000, 4'b0000, 1, 1, 8'hA3, 4'b0000, 1, 3);
    runStep("rs.f0",    0, 4'b1000, 32'hF0000000, 4'b0000, 1, 1, 8'hF0, 4'b1000, 1, 3);
    runStep("rs.f1",    0, 4'b1000, 32'hF1000000, 4'b0000, 1, 1, 8'hF1, 4'b1000, 1, 3);
    runStep("rs.f2",    0, 4'b1000, 32'hF2000000, 4'b0000, 1, 1, 8'hF2, 4'b1000, 1, 3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rs.during", 0, 0, 8'h00, 4'b0000, 0, 0);
    #1;
    rst      = 1'b0;
    reqValid = '0;
    runStep("rs.a.idle", 0, 4'b1001, 32'h73000070, 4'b1001, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("rs.a.tag",  0, 4'b1001, 32'h73000070, 4'b1001, 1, 1, 8'hA0, 4'b0000, 1, 0);
    runStep("rs.a.byte", 0, 4'b1001, 32'h73000070, 4'b1001, 1, 1, 8'h70, 4'b0001, 1, 0);
    runStep("rs.b.idle", 0, 4'b1000, 32'h73000000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("rs.b.tag",  0, 4'b1000, 32'h73000000, 4'b1000, 1, 1, 8'hA3, 4'b0000, 1, 3);
    runStep("rs.b.byte", 0, 4'b1000, 32'h73000000, 4'b1000, 1, 1, 8'h73, 4'b1000, 1, 3);
    runStep("rs.end",    0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);

    $display("[TB] untagged instance, pointer at 2");
    doReset();
    runStep("nh.idle0", 1, 4'b0010, 32'h00003100, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("nh.b31",   1, 4'b0010, 32'h00003100, 4'b0010, 1, 1, 8'h31, 4'b0010, 1, 1);
    runStep("nh.idle1", 1, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("nh.idle2", 1, 4'b1010, 32'h43004100, 4'b1010, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("nh.b43",   1, 4'b1010, 32'h43004100, 4'b1010, 1, 1, 8'h43, 4'b1000, 1, 3);
    runStep("nh.idle3", 1, 4'b0010, 32'h00004100, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 0);
    runStep("nh.b41",   1, 4'b0010, 32'h00004100, 4'b0010, 1, 1, 8'h41, 4'b0010, 1, 1);
    runStep("nh.idle4", 1, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
